top_key_tx: RTL and testbench



---
 rtl/top_key_tx.sv | 191 +++++++++++++++++++
 tb/tb_top_key_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_key_tx.sv
// rtl/top_key_tx.sv - key stream source: push FIFO feeding a valid/accept key port
//
// Buffers words from the local push port in a depth_p-entry FIFO and presents
// the head on key_valid_o/key_data_o, holding it until key_accept_i. After each
// accepted beat key_valid_o is forced low for gap_p cycles.
//
// Optional build macro: TOP_KEY_TX_CNT_EN adds beat_cnt_o, a 16-bit wrapping
// count of accepted key beats, cleared by flush_i.
//
// Ports:
//   main_clk_i     clock
//   main_rst_an_i  asynchronous reset, active-low
//   push_valid_i   producer offers push_data_i
//   push_accept_o  FIFO not full (from registered level)
//   push_data_i    word to enqueue
//   key_valid_o    key beat valid
//   key_accept_i   sink takes the beat
//   key_data_o     key beat data (registered FIFO head)
//   flush_i        synchronous discard of all buffered words
//   level_o        words held, including the one on key_data_o
//   beat_cnt_o     accepted beat count (TOP_KEY_TX_CNT_EN only)
//   idle_o         FIFO empty and state IDLE
module top_key_tx #(
    parameter int depth_p = 4,
    parameter int width_p = 9,
    parameter int gap_p   = 0
) (
    input  logic                           main_clk_i,
    input  logic                           main_rst_an_i,
    input  logic                           push_valid_i,
    output logic                           push_accept_o,
    input  logic [width_p-1:0]             push_data_i,
    output logic                           key_valid_o,
    input  logic                           key_accept_i,
    output logic [width_p-1:0]             key_data_o,
    input  logic                           flush_i,
    output logic [$clog2(depth_p+1)-1:0]   level_o,
`ifdef TOP_KEY_TX_CNT_EN
    output logic [15:0]                    beat_cnt_o,
`endif
    output logic                           idle_o
);

    localparam int LW = $clog2(depth_p + 1);
    localparam int PW = $clog2(depth_p);
    localparam logic [3:0] GAP_LOAD = 4'(gap_p);
    localparam bit GAP_EN = (gap_p > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [width_p-1:0]    mem [depth_p];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_nxt;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         remaining;
    logic [3:0]            gap_cnt_q;
    logic [width_p-1:0]    key_data_q;
    logic [width_p-1:0]    head_d;
    logic                  push_fire;
    logic                  pop;
    logic                  words_avail;
    logic                  load_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(depth_p - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push_fire = push_valid_i & push_accept_o;
    assign pop       = key_valid_o & key_accept_i;

    // Words left after this cycle's pop; a same-cycle push also counts as
    // available so an empty FIFO reaches the key port one cycle after the push.
    assign remaining   = level_q - LW'(pop);
    assign words_avail = (remaining != '0) | push_fire;
    assign rd_nxt      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // Next head: stored word if one remains, otherwise bypass the incoming push.
    assign head_d    = (remaining == '0) ? push_data_i : mem[rd_nxt];
    assign load_data = (state_d == ST_SEND) && ((state_q != ST_SEND) || pop);

    // State register
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (words_avail) begin
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (pop) begin
                        if (GAP_EN) begin
                            state_d = ST_GAP;
                        end else if (words_avail) begin
                            state_d = ST_SEND;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 4'd1) begin
                        state_d = words_avail ? ST_SEND : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        key_valid_o   = (state_q == ST_SEND);
        key_data_o    = key_data_q;
        level_o       = level_q;
        push_accept_o = (level_q < LW'(depth_p));
        idle_o        = (level_q == '0) && (state_q == ST_IDLE);
    end

    // Storage has no reset; only slots below level are ever read.
    always_ff @(posedge main_clk_i) begin
        if (push_fire && !flush_i) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            gap_cnt_q  <= '0;
            key_data_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            gap_cnt_q <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            rd_ptr_q <= rd_nxt;
            level_q  <= level_q + LW'(push_fire) - LW'(pop);
            if (load_data) begin
                key_data_q <= head_d;
            end
            if (pop && GAP_EN) begin
                gap_cnt_q <= GAP_LOAD;
            end else if ((state_q == ST_GAP) && (gap_cnt_q != 4'd0)) begin
                gap_cnt_q <= gap_cnt_q - 4'd1;
            end
        end
    end

`ifdef TOP_KEY_TX_CNT_EN
    logic [15:0] beat_cnt_q;

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            beat_cnt_q <= '0;
        end else if (flush_i) begin
            beat_cnt_q <= '0;
        end else if (pop) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`endif

endmodule

// File: tb/tb_top_key_tx.sv
// tb/tb_top_key_tx.sv - self-checking bench for top_key_tx
module tb_top_key_tx;

    localparam int DEPTH = 4;
    localparam int WIDTH = 9;
    localparam int GAP3  = 3;
    localparam int NWORDS = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut0: gap_p = 0
    logic             pv0 = 1'b0, ka0 = 1'b0, fl0 = 1'b0;
    logic [WIDTH-1:0] pd0 = '0;
    logic             pa0, kv0, id0;
    logic [WIDTH-1:0] kd0;
    logic [2:0]       lv0;
    // dut3: gap_p = 3
    logic             pv3 = 1'b0, ka3 = 1'b0, fl3 = 1'b0;
    logic [WIDTH-1:0] pd3 = '0;
    logic             pa3, kv3, id3;
    logic [WIDTH-1:0] kd3;
    logic [2:0]       lv3;
`ifdef TOP_KEY_TX_CNT_EN
    logic [15:0]      bc0, bc3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    top_key_tx #(.depth_p(DEPTH), .width_p(WIDTH), .gap_p(0)) u_dut0 (
        .main_clk_i(clk), .main_rst_an_i(rst_n),
        .push_valid_i(pv0), .push_accept_o(pa0), .push_data_i(pd0),
        .key_valid_o(kv0), .key_accept_i(ka0), .key_data_o(kd0),
        .flush_i(fl0), .level_o(lv0),
`ifdef TOP_KEY_TX_CNT_EN
        .beat_cnt_o(bc0),
`endif
        .idle_o(id0)
    );

    top_key_tx #(.depth_p(DEPTH), .width_p(WIDTH), .gap_p(GAP3)) u_dut3 (
        .main_clk_i(clk), .main_rst_an_i(rst_n),
        .push_valid_i(pv3), .push_accept_o(pa3), .push_data_i(pd3),
        .key_valid_o(kv3), .key_accept_i(ka3), .key_data_o(kd3),
        .flush_i(fl3), .level_o(lv3),
`ifdef TOP_KEY_TX_CNT_EN
        .beat_cnt_o(bc3),
`endif
        .idle_o(id3)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_cmp++; if (kv0 !== 1'b0) begin n_err++; $display("FAIL reset_kv0: got %b want 0", kv0); end
        n_cmp++; if (kd0 !== 9'h000) begin n_err++; $display("FAIL reset_kd0: got %h want 000", kd0); end
        n_cmp++; if (pa0 !== 1'b1) begin n_err++; $display("FAIL reset_pa0: got %b want 1", pa0); end
        n_cmp++; if (lv0 !== 3'd0) begin n_err++; $display("FAIL reset_lv0: got %0d want 0", lv0); end
        n_cmp++; if (id0 !== 1'b1) begin n_err++; $display("FAIL reset_id0: got %b want 1", id0); end
        n_cmp++; if (kv3 !== 1'b0 || id3 !== 1'b1) begin n_err++; $display("FAIL reset_dut3: got kv=%b idle=%b want 0/1", kv3, id3); end
`ifdef TOP_KEY_TX_CNT_EN
        n_cmp++; if (bc0 !== 16'h0) begin n_err++; $display("FAIL reset_bc0: got %h want 0000", bc0); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        pv0 = 1'b1; pd0 = 9'h0A5; ka0 = 1'b1;
        step();
        pv0 = 1'b0;
        n_cmp++; if (kv0 !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", kv0); end
        n_cmp++; if (kd0 !== 9'h0A5) begin n_err++; $display("FAIL single_data: got %h want 0a5", kd0); end
        n_cmp++; if (lv0 !== 3'd1) begin n_err++; $display("FAIL single_level1: got %0d want 1", lv0); end
        step();
        n_cmp++; if (lv0 !== 3'd0) begin n_err++; $display("FAIL single_level0: got %0d want 0", lv0); end
        n_cmp++; if (kv0 !== 1'b0 || id0 !== 1'b1) begin n_err++; $display("FAIL single_idle: got kv=%b idle=%b want 0/1", kv0, id0); end
        ka0 = 1'b0;
    endtask

    task automatic test_fill_drain();
        ka0 = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            n_cmp++; if (pa0 !== 1'b1) begin n_err++; $display("FAIL fill_accept%0d: got %b want 1", i, pa0); end
            pv0 = 1'b1; pd0 = WIDTH'(i);
            step();
        end
        // offered while full: must be refused
        pd0 = 9'h1FF;
        step();
        pv0 = 1'b0;
        n_cmp++; if (pa0 !== 1'b0) begin n_err++; $display("FAIL full_accept: got %b want 0", pa0); end
        n_cmp++; if (lv0 !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", lv0); end
        n_cmp++; if (kv0 !== 1'b1 || kd0 !== 9'h001) begin n_err++; $display("FAIL full_head: got kv=%b data=%h want 1/001", kv0, kd0); end
        ka0 = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_cmp++; if (kv0 !== 1'b1 || kd0 !== WIDTH'(i)) begin n_err++; $display("FAIL drain_beat%0d: got kv=%b data=%h want 1/%h", i, kv0, kd0, WIDTH'(i)); end
            step();
            if (i == 1) begin
                n_cmp++; if (pa0 !== 1'b1) begin n_err++; $display("FAIL accept_after_pop: got %b want 1", pa0); end
            end
        end
        n_cmp++; if (kv0 !== 1'b0 || lv0 !== 3'd0) begin n_err++; $display("FAIL drain_end: got kv=%b level=%0d want 0/0", kv0, lv0); end
        ka0 = 1'b0;
    endtask

    task automatic test_gap();
        int beats;
        logic exp_v;
        ka3 = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            pv3 = 1'b1; pd3 = WIDTH'(i);
            step();
        end
        pv3 = 1'b0;
        n_cmp++; if (lv3 !== 3'd4 || kv3 !== 1'b1 || kd3 !== 9'h001) begin n_err++; $display("FAIL gap_setup: got level=%0d kv=%b data=%h want 4/1/001", lv3, kv3, kd3); end
        ka3 = 1'b1;
        beats = 0;
        for (int t = 0; t < 17; t++) begin
            exp_v = ((t % (GAP3 + 1)) == 0) && ((t / (GAP3 + 1)) < DEPTH);
            n_cmp++; if (kv3 !== exp_v) begin n_err++; $display("FAIL gap_valid_t%0d: got %b want %b", t, kv3, exp_v); end
            if (exp_v) begin
                n_cmp++; if (kd3 !== WIDTH'(t / (GAP3 + 1) + 1)) begin n_err++; $display("FAIL gap_data_t%0d: got %h want %h", t, kd3, WIDTH'(t / (GAP3 + 1) + 1)); end
            end
            if (t == 13) begin
                n_cmp++; if (beats != 4 || lv3 !== 3'd0) begin n_err++; $display("FAIL gap_13cycles: got beats=%0d level=%0d want 4/0", beats, lv3); end
                n_cmp++; if (id3 !== 1'b0) begin n_err++; $display("FAIL gap_not_idle: got %b want 0", id3); end
            end
            if (t == 16) begin
                n_cmp++; if (id3 !== 1'b1) begin n_err++; $display("FAIL gap_idle: got %b want 1", id3); end
            end
            if (kv3 && ka3) beats++;
            step();
        end
        ka3 = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] expq[$];
        logic [WIDTH-1:0] exp_w;
        logic [WIDTH-1:0] prev_data;
        logic             prev_stall;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (got < NWORDS && cyc < 20000) begin
            if (prev_stall) begin
                n_cmp++; if (kv0 !== 1'b1 || kd0 !== prev_data) begin n_err++; $display("FAIL rand_hold_c%0d: got kv=%b data=%h want 1/%h", cyc, kv0, kd0, prev_data); end
            end
            n_cmp++; if (lv0 !== 3'(expq.size())) begin n_err++; $display("FAIL rand_level_c%0d: got %0d want %0d", cyc, lv0, expq.size()); end
            n_cmp++; if (pa0 !== (expq.size() < DEPTH)) begin n_err++; $display("FAIL rand_accept_c%0d: got %b want %b", cyc, pa0, expq.size() < DEPTH); end
            n_cmp++; if (kv0 !== (expq.size() != 0)) begin n_err++; $display("FAIL rand_valid_c%0d: got %b want %b", cyc, kv0, expq.size() != 0); end
            ka0 = ($urandom_range(0, 99) < 55);
            pv0 = (sent < NWORDS) && ($urandom_range(0, 99) < 70);
            pd0 = WIDTH'($urandom);
            if (kv0 && ka0) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL rand_extra_beat_c%0d: got data=%h want no beat", cyc, kd0);
                end else begin
                    exp_w = expq.pop_front();
                    n_cmp++; if (kd0 !== exp_w) begin n_err++; $display("FAIL rand_data_w%0d: got %h want %h", got, kd0, exp_w); end
                    got++;
                end
            end
            if (pv0 && pa0) begin
                expq.push_back(pd0);
                sent++;
            end
            prev_stall = kv0 && !ka0;
            prev_data  = kd0;
            step();
            cyc++;
        end
        pv0 = 1'b0; ka0 = 1'b0;
        n_cmp++; if (got != NWORDS) begin n_err++; $display("FAIL rand_count: got %0d words want %0d", got, NWORDS); end
    endtask

    task automatic test_flush();
        ka0 = 1'b0;
        pv0 = 1'b1; pd0 = 9'h011; step();
        pd0 = 9'h022; step();
        pd0 = 9'h033; step();
        pv0 = 1'b0;
        n_cmp++; if (lv0 !== 3'd3 || kv0 !== 1'b1 || kd0 !== 9'h011) begin n_err++; $display("FAIL flush_setup: got level=%0d kv=%b data=%h want 3/1/011", lv0, kv0, kd0); end
        fl0 = 1'b1; pv0 = 1'b1; pd0 = 9'h155;
        step();
        fl0 = 1'b0; pv0 = 1'b0;
        n_cmp++; if (lv0 !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", lv0); end
        n_cmp++; if (kv0 !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", kv0); end
        n_cmp++; if (id0 !== 1'b1 || pa0 !== 1'b1) begin n_err++; $display("FAIL flush_idle: got idle=%b accept=%b want 1/1", id0, pa0); end
        ka0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (kv0 !== 1'b0) begin n_err++; $display("FAIL flush_dropped%0d: got kv=%b data=%h want no beat", i, kv0, kd0); end
        end
        pv0 = 1'b1; pd0 = 9'h0C3;
        step();
        pv0 = 1'b0;
        n_cmp++; if (kv0 !== 1'b1 || kd0 !== 9'h0C3) begin n_err++; $display("FAIL flush_next: got kv=%b data=%h want 1/0c3", kv0, kd0); end
        step();
        n_cmp++; if (lv0 !== 3'd0) begin n_err++; $display("FAIL flush_next_level: got %0d want 0", lv0); end
        ka0 = 1'b0;
    endtask

    task automatic test_reset_mid_beat();
        ka0 = 1'b0;
        pv0 = 1'b1; pd0 = 9'h1A7;
        step();
        pv0 = 1'b0;
        n_cmp++; if (kv0 !== 1'b1 || kd0 !== 9'h1A7) begin n_err++; $display("FAIL rst_mid_setup: got kv=%b data=%h want 1/1a7", kv0, kd0); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (kv0 !== 1'b0 || kd0 !== 9'h000) begin n_err++; $display("FAIL rst_mid_out: got kv=%b data=%h want 0/000", kv0, kd0); end
        n_cmp++; if (lv0 !== 3'd0 || pa0 !== 1'b1 || id0 !== 1'b1) begin n_err++; $display("FAIL rst_mid_status: got level=%0d accept=%b idle=%b want 0/1/1", lv0, pa0, id0); end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef TOP_KEY_TX_CNT_EN
    task automatic test_beat_cnt();
        int model_cnt;
        int cyc;
        fl0 = 1'b1; step(); fl0 = 1'b0;
        model_cnt = 0; cyc = 0;
        ka0 = 1'b1; pv0 = 1'b1;
        while (model_cnt < 65536 && cyc < 70000) begin
            pd0 = WIDTH'($urandom);
            if (kv0 && ka0) model_cnt++;
            step();
            cyc++;
        end
        n_cmp++; if (bc0 !== 16'(model_cnt)) begin n_err++; $display("FAIL cnt_wrap: got %h want %h", bc0, 16'(model_cnt)); end
        while (model_cnt < 65541 && cyc < 70100) begin
            if (kv0 && ka0) model_cnt++;
            step();
            cyc++;
        end
        pv0 = 1'b0; ka0 = 1'b0;
        n_cmp++; if (bc0 !== 16'd5) begin n_err++; $display("FAIL cnt_five: got %h want 0005", bc0); end
        fl0 = 1'b1; step(); fl0 = 1'b0;
        n_cmp++; if (bc0 !== 16'd0) begin n_err++; $display("FAIL cnt_flush: got %h want 0000", bc0); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_gap();
        test_random();
        test_flush();
        test_reset_mid_beat();
`ifdef TOP_KEY_TX_CNT_EN
        test_beat_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
